// File: rtl/perceptron_ctrl_pkg.sv
// Shared types for the perceptron training sequencer: the core's fixed-point format,
// sequencer states and the sample-table entry.
package perceptron_ctrl_pkg;

    localparam int unsigned SFP_W        = 16;
    localparam int unsigned SFP_FRAC     = 8;
    localparam int unsigned SAMPLE_UNITS = 2;

    // Mirrors the core's Q8.8 signed fixed-point type.
    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp ONE = sfp'(1 << SFP_FRAC);

    typedef enum logic [3:0] {
        StIdle,
        StClear,
        StPresent,
        StSettle,
        StScore,
        StUpdate,
        StEpochEnd,
        StDone,
        StInfer
    } seq_state_t;

    typedef struct packed {
        sfp [SAMPLE_UNITS-1:0] values;
        sfp                    expected;
    } sample_t;

    function automatic bit sfp_class(input sfp x);
        return x > sfp'(0);
    endfunction

endpackage

// File: rtl/perceptron_sample_table.sv
// Programmable training-sample register file: one write port, one asynchronous read port.
// Not reset, so a loaded table survives a sequencer reset.
module perceptron_sample_table
    import perceptron_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 4,
    parameter int unsigned ADDR_W      = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  sample_t           wdata,
    input  logic [ADDR_W-1:0] raddr,
    output sample_t           rdata
);

    sample_t mem [NUM_SAMPLES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/perceptron_train_sequencer.sv
// Replays the sample table through one perceptron core epoch by epoch, gates its weight
// update, stops on convergence or epoch limit, then serves a valid/ready inference port.
module perceptron_train_sequencer
    import perceptron_ctrl_pkg::*;
#(
    parameter int unsigned INPUT_UNITS   = SAMPLE_UNITS,
    parameter int unsigned NUM_SAMPLES   = 4,
    parameter int unsigned MAX_EPOCHS    = 10,
    parameter int unsigned SETTLE_CYCLES = 1,
    localparam int unsigned AddrW   = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
    localparam int unsigned EpochW  = $clog2(MAX_EPOCHS + 1),
    localparam int unsigned ErrW    = $clog2(NUM_SAMPLES + 1),
    localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_we,
    input  logic [AddrW-1:0]  cfg_addr,
    input  sfp                cfg_values [INPUT_UNITS],
    input  sfp                cfg_expected,
    output logic              core_rst,
    output sfp                core_values [INPUT_UNITS],
    output sfp                core_expected,
    output logic              core_training,
    input  sfp                core_prediction,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [EpochW-1:0] epoch_count,
    output logic [ErrW-1:0]   error_count,
    input  logic              infer_valid,
    output logic              infer_ready,
    input  sfp                infer_values [INPUT_UNITS],
    output logic              result_valid,
    output logic              result_class
);

    seq_state_t         state_q, state_d;
    logic [AddrW-1:0]   idx_q, idx_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [EpochW-1:0]  epoch_q, epoch_d, epoch_inc;
    logic [ErrW-1:0]    err_q, err_d;
    logic               done_q, done_d;
    logic               conv_q, conv_d;
    logic               res_q, res_d;
    logic               rst_q;
    sfp                 infer_q [INPUT_UNITS];
    sfp                 infer_d [INPUT_UNITS];
    sample_t            wr_sample, rd_sample;
    logic               wr_en, drive_sample, settle_last, miss;

    assign drive_sample = state_q inside {StPresent, StSettle, StScore, StUpdate};
    assign busy         = state_q inside {StClear, StPresent, StSettle, StScore, StUpdate,
                                          StEpochEnd};
    assign settle_last  = settle_q == SettleW'(SETTLE_CYCLES - 1);
    assign epoch_inc    = epoch_q + EpochW'(1);
    assign miss         = sfp_class(core_prediction) != sfp_class(rd_sample.expected);
    assign wr_en        = cfg_we && !busy && (32'(cfg_addr) < NUM_SAMPLES);

    always_comb begin
        wr_sample          = '0;
        wr_sample.expected = cfg_expected;
        for (int i = 0; i < INPUT_UNITS; i++) begin
            wr_sample.values[i] = cfg_values[i];
        end
    end

    perceptron_sample_table #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .ADDR_W      (AddrW)
    ) u_table (
        .clk   (clk),
        .we    (wr_en),
        .waddr (cfg_addr),
        .wdata (wr_sample),
        .raddr (idx_q),
        .rdata (rd_sample)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        epoch_d  = epoch_q;
        err_d    = err_q;
        done_d   = done_q;
        conv_d   = conv_q;
        res_d    = 1'b0;
        for (int i = 0; i < INPUT_UNITS; i++) begin
            infer_d[i] = infer_q[i];
        end

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StClear;
            end
            StClear: begin
                epoch_d = '0;
                err_d   = '0;
                done_d  = 1'b0;
                conv_d  = 1'b0;
                idx_d   = '0;
                for (int i = 0; i < INPUT_UNITS; i++) begin
                    infer_d[i] = '0;
                end
                state_d = StPresent;
            end
            StPresent: begin
                settle_d = '0;
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_last) state_d = StScore;
                else             settle_d = settle_q + SettleW'(1);
            end
            StScore: begin
                if (miss) err_d = err_q + ErrW'(1);
                state_d = StUpdate;
            end
            StUpdate: begin
                if (idx_q == AddrW'(NUM_SAMPLES - 1)) begin
                    state_d = StEpochEnd;
                end else begin
                    idx_d   = idx_q + AddrW'(1);
                    state_d = StPresent;
                end
            end
            StEpochEnd: begin
                epoch_d = epoch_inc;
                if (err_q == '0) begin
                    conv_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (epoch_inc == EpochW'(MAX_EPOCHS)) begin
                    conv_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    err_d   = '0;
                    idx_d   = '0;
                    state_d = StPresent;
                end
            end
            StDone: begin
                // A restart takes priority over a same-cycle inference request.
                if (start) begin
                    state_d = StClear;
                end else if (infer_valid) begin
                    for (int i = 0; i < INPUT_UNITS; i++) begin
                        infer_d[i] = infer_values[i];
                    end
                    settle_d = '0;
                    state_d  = StInfer;
                end
            end
            StInfer: begin
                if (settle_last) begin
                    res_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    settle_d = settle_q + SettleW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            settle_q <= '0;
            epoch_q  <= '0;
            err_q    <= '0;
            done_q   <= 1'b0;
            conv_q   <= 1'b0;
            res_q    <= 1'b0;
            rst_q    <= 1'b1;
            for (int i = 0; i < INPUT_UNITS; i++) begin
                infer_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            epoch_q  <= epoch_d;
            err_q    <= err_d;
            done_q   <= done_d;
            conv_q   <= conv_d;
            res_q    <= res_d;
            rst_q    <= 1'b0;
            for (int i = 0; i < INPUT_UNITS; i++) begin
                infer_q[i] <= infer_d[i];
            end
        end
    end

    // Inference inputs stay on the core in DONE so the result is sampled with them applied.
    always_comb begin
        for (int i = 0; i < INPUT_UNITS; i++) begin
            if (drive_sample)                             core_values[i] = rd_sample.values[i];
            else if (state_q inside {StDone, StInfer}) core_values[i] = infer_q[i];
            else                                          core_values[i] = '0;
        end
    end

    assign core_expected = drive_sample ? rd_sample.expected : '0;
    assign core_rst      = rst_q || (state_q == StClear);
    assign core_training = state_q == StUpdate;
    assign done          = done_q;
    assign converged     = conv_q;
    assign epoch_count   = epoch_q;
    assign error_count   = err_q;
    assign infer_ready   = (state_q == StDone) && !start;
    assign result_valid  = res_q;
    assign result_class  = res_q && sfp_class(core_prediction);

endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// Scoreboard bench: a behavioural perceptron core drives the DUT, a reference model predicts
// every update, epoch outcome and inference result, and a monitor compares them.
module tb_perceptron_train_sequencer;
    import perceptron_ctrl_pkg::*;

    localparam int unsigned NI = 2;
    localparam int unsigned NS = 4;
    localparam int unsigned ME = 10;
    localparam int unsigned SC = 2;

    typedef struct packed { sfp x0; sfp x1; sfp e; logic first; } train_ev_t;
    typedef struct packed { int epochs; logic conv; int errs; } done_ev_t;

    logic       clk = 1'b0;
    logic       rst, start, cfg_we, infer_valid;
    logic [1:0] cfg_addr;
    sfp         cfg_values [NI];
    sfp         cfg_expected;
    logic       core_rst, core_training, busy, done, converged;
    sfp         core_values [NI];
    sfp         core_expected, core_prediction;
    logic [3:0] epoch_count;
    logic [2:0] error_count;
    logic       infer_ready, result_valid, result_class;
    sfp         infer_values [NI];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    train_ev_t train_q[$];
    done_ev_t  done_q[$];
    bit        res_q[$];

    sfp tx0 [NS];
    sfp tx1 [NS];
    sfp te  [NS];
    int rw0 = 0, rw1 = 0, rb = 0;
    int cw0 = 0, cw1 = 0, cb = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    perceptron_train_sequencer #(
        .INPUT_UNITS   (NI),
        .NUM_SAMPLES   (NS),
        .MAX_EPOCHS    (ME),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_values      (cfg_values),
        .cfg_expected    (cfg_expected),
        .core_rst        (core_rst),
        .core_values     (core_values),
        .core_expected   (core_expected),
        .core_training   (core_training),
        .core_prediction (core_prediction),
        .busy            (busy),
        .done            (done),
        .converged       (converged),
        .epoch_count     (epoch_count),
        .error_count     (error_count),
        .infer_valid     (infer_valid),
        .infer_ready     (infer_ready),
        .infer_values    (infer_values),
        .result_valid    (result_valid),
        .result_class    (result_class)
    );

    function automatic sfp calc_pred(int w0, int w1, int b, sfp x0, sfp x1);
        int s;
        s = (w0 * int'(x0) + w1 * int'(x1)) >>> SFP_FRAC;
        return sfp'(s + b);
    endfunction

    function automatic int lerr(sfp e, sfp p);
        return int'(e) - (sfp_class(p) ? int'(ONE) : 0);
    endfunction

    function automatic int step(int err, sfp x);
        return (err * int'(x)) >>> SFP_FRAC;
    endfunction

    function automatic sfp rnd_sfp();
        return sfp'(int'($urandom_range(0, 512)) - 256);
    endfunction

    // Behavioural perceptron core: combinational prediction, rule-based update on the gate.
    assign core_prediction = calc_pred(cw0, cw1, cb, core_values[0], core_values[1]);

    always @(posedge clk) begin
        if (core_rst) begin
            cw0 <= 0;
            cw1 <= 0;
            cb  <= 0;
        end else if (core_training) begin
            cw0 <= cw0 + step(lerr(core_expected, core_prediction), core_values[0]);
            cw1 <= cw1 + step(lerr(core_expected, core_prediction), core_values[1]);
            cb  <= cb + lerr(core_expected, core_prediction);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    // Reference: whole training run computed sample by sample from the table.
    task automatic ref_train();
        int  w0, w1, b, errs, ep, err;
        bit  conv;
        sfp  p;
        w0 = 0; w1 = 0; b = 0; conv = 0; errs = 0;
        for (ep = 1; ep <= int'(ME); ep++) begin
            errs = 0;
            for (int s = 0; s < int'(NS); s++) begin
                train_q.push_back('{x0: tx0[s], x1: tx1[s], e: te[s], first: (s == 0)});
                p = calc_pred(w0, w1, b, tx0[s], tx1[s]);
                if (sfp_class(p) != sfp_class(te[s])) errs++;
                err = lerr(te[s], p);
                w0 += step(err, tx0[s]);
                w1 += step(err, tx1[s]);
                b  += err;
            end
            if (errs == 0) begin
                conv = 1;
                break;
            end
            if (ep == int'(ME)) break;
        end
        done_q.push_back('{epochs: ep, conv: conv, errs: errs});
        rw0 = w0; rw1 = w1; rb = b;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an update, a finish or a result.
    initial begin
        train_ev_t tev;
        done_ev_t  dev;
        bit        rc;
        int        last_train;
        logic      prev_done;
        last_train = 0;
        prev_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (infer_valid && infer_ready) acc_cyc = cyc;
            if (core_training) begin
                if (train_q.size() == 0) begin
                    chk("unexpected_update", 1, 0);
                end else begin
                    tev = train_q.pop_front();
                    chk("update_x0", int'(core_values[0]), int'(tev.x0));
                    chk("update_x1", int'(core_values[1]), int'(tev.x1));
                    chk("update_expected", int'(core_expected), int'(tev.e));
                    if (!tev.first) chk("sample_spacing", cyc - last_train, int'(SC) + 3);
                end
                last_train = cyc;
            end
            if (done && !prev_done && !rst) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    dev = done_q.pop_front();
                    chk("epoch_count", int'(epoch_count), dev.epochs);
                    chk("converged", int'(converged), int'(dev.conv));
                    chk("error_count", int'(error_count), dev.errs);
                    chk("busy_at_done", int'(busy), 0);
                end
            end
            prev_done = done;
            if (result_valid) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    rc = res_q.pop_front();
                    chk("result_class", int'(result_class), int'(rc));
                    chk("result_latency", cyc - acc_cyc, int'(SC) + 1);
                end
            end
        end
    end

    task automatic write_tbl(input int a, input sfp x0, input sfp x1, input sfp e);
        cfg_we        = 1'b1;
        cfg_addr      = 2'(a);
        cfg_values[0] = x0;
        cfg_values[1] = x1;
        cfg_expected  = e;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tx0[a] = x0; tx1[a] = x1; te[a] = e;
    endtask

    task automatic pulse_start();
        ref_train();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_reached", int'(done), 1);
    endtask

    task automatic do_infer(input sfp x0, input sfp x1);
        int n;
        n = 0;
        while (!infer_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("infer_ready", int'(infer_ready), 1);
        res_q.push_back(sfp_class(calc_pred(rw0, rw1, rb, x0, x1)));
        infer_valid     = 1'b1;
        infer_values[0] = x0;
        infer_values[1] = x1;
        @(posedge clk); #1;
        infer_valid = 1'b0;
        repeat (SC + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_expected = '0;
        infer_valid = 1'b0;
        for (int i = 0; i < int'(NI); i++) begin
            cfg_values[i]   = '0;
            infer_values[i] = '0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_core_rst", int'(core_rst), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_epoch", int'(epoch_count), 0);
        chk("reset_infer_ready", int'(infer_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_core_rst", int'(core_rst), 0);

        // AND table, then inference on the trained core.
        write_tbl(0, 0, 0, 0);
        write_tbl(1, 0, ONE, 0);
        write_tbl(2, ONE, 0, 0);
        write_tbl(3, ONE, ONE, ONE);
        pulse_start();
        wait_done();
        chk("and_converged", int'(converged), 1);
        do_infer(ONE, ONE);
        do_infer(0, ONE);

        // XOR table with a dropped write and an ignored start mid epoch 2.
        write_tbl(0, 0, 0, 0);
        write_tbl(1, 0, ONE, ONE);
        write_tbl(2, ONE, 0, ONE);
        write_tbl(3, ONE, ONE, 0);
        pulse_start();
        n = 0;
        while (epoch_count != 4'd1 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_values[0] = ONE; cfg_values[1] = ONE;
        cfg_expected = 0; start = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        wait_done();
        chk("xor_epochs", int'(epoch_count), int'(ME));
        chk("xor_converged", int'(converged), 0);

        // Reset during an update, then retrain from the preserved table.
        pulse_start();
        n = 0;
        @(negedge clk);
        while (!core_training && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_core_rst", int'(core_rst), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_training", int'(core_training), 0);
        rst = 1'b0;
        train_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        pulse_start();
        wait_done();

        // start and infer_valid together in DONE.
        ref_train();
        start = 1'b1; infer_valid = 1'b1;
        infer_values[0] = ONE; infer_values[1] = ONE;
        #1;
        chk("start_wins_ready", int'(infer_ready), 0);
        @(posedge clk); #1;
        start = 1'b0; infer_valid = 1'b0;
        chk("restart_core_rst", int'(core_rst), 1);
        wait_done();

        // Randomised tables and inferences.
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < int'(NS); s++) begin
                write_tbl(s, rnd_sfp(), rnd_sfp(), ($urandom_range(0, 1) == 1) ? ONE : sfp'(0));
            end
            pulse_start();
            wait_done();
            for (int k = 0; k < 3; k++) do_infer(rnd_sfp(), rnd_sfp());
        end

        repeat (4) @(posedge clk);
        chk("train_q_empty", train_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
